// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle control unit.
package cu_pkg;

    // Internal width of the ALU operation field carried in the control word.
    localparam int unsigned CW_ALU_W = 3;

    // Sequencer states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    // Opcode values (compared against an OP_W-wide opcode after a cast).
    localparam int unsigned OP_NOP  = 0;
    localparam int unsigned OP_ADD3 = 1;
    localparam int unsigned OP_ST   = 2;
    localparam int unsigned OP_ADD2 = 3;
    localparam int unsigned OP_ADDI = 4;
    localparam int unsigned OP_LD   = 5;

    // Writeback-source select encodings.
    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_ST  = 2'b10;

    // All ALU-using opcodes perform an add.
    localparam logic [CW_ALU_W-1:0] ALU_ADD = 3'b000;

    // Datapath control word registered in DECODE.
    typedef struct packed {
        logic                rg_wr;
        logic                dataMem_wr;
        logic [CW_ALU_W-1:0] alu_op;
        logic                RegOut;
        logic [1:0]          M2Reg;
        logic                immCalc;
    } ctrl_word_t;

    // An instruction needs a data-memory phase if it stores or loads.
    function automatic logic cw_uses_mem(input ctrl_word_t cw);
        return cw.dataMem_wr || (cw.M2Reg == M2R_MEM);
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: control word plus halt/nop/legal flags.
module cu_decode
    import cu_pkg::*;
#(
    parameter int unsigned     OP_W    = 7,
    parameter logic [OP_W-1:0] HALT_OP = OP_W'(7'h7F)
) (
    input  logic [OP_W-1:0] op_i,
    output ctrl_word_t      cw_o,
    output logic            legal_o,
    output logic            halt_o,
    output logic            nop_o
);

    // Map the opcode onto the datapath controls it needs.
    always_comb begin
        cw_o    = '0;
        legal_o = 1'b1;
        halt_o  = 1'b0;
        nop_o   = 1'b0;
        if (op_i == HALT_OP) begin
            halt_o = 1'b1;
        end else begin
            unique case (op_i)
                OP_W'(OP_NOP): nop_o = 1'b1;
                OP_W'(OP_ADD3): begin
                    cw_o.rg_wr  = 1'b1;
                    cw_o.alu_op = ALU_ADD;
                    cw_o.M2Reg  = M2R_ALU;
                end
                OP_W'(OP_ST): begin
                    cw_o.dataMem_wr = 1'b1;
                    cw_o.alu_op     = ALU_ADD;
                    cw_o.M2Reg      = M2R_ST;
                end
                OP_W'(OP_ADD2): begin
                    cw_o.rg_wr  = 1'b1;
                    cw_o.alu_op = ALU_ADD;
                    cw_o.RegOut = 1'b1;
                end
                OP_W'(OP_ADDI): begin
                    cw_o.rg_wr   = 1'b1;
                    cw_o.alu_op  = ALU_ADD;
                    cw_o.RegOut  = 1'b1;
                    cw_o.immCalc = 1'b1;
                end
                OP_W'(OP_LD): begin
                    cw_o.rg_wr  = 1'b1;
                    cw_o.alu_op = ALU_ADD;
                    cw_o.RegOut = 1'b1;
                    cw_o.M2Reg  = M2R_MEM;
                end
                default: legal_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB over a
// shared req/ack memory port and pulses datapath controls in-phase.
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// FETCH  | instruction fetch request outstanding; ack loads IR and bumps PC
// DECODE | opcode decoded, control word captured
// EXEC   | ALU cycle
// MEM    | data request outstanding (LD/ST); ST writes here
// WB     | register-file write, instruction retires
// HALT   | stopped by HALT_OP, waiting for start
module multicycle_cu
    import cu_pkg::*;
#(
    parameter int unsigned     OP_W     = 7,
    parameter int unsigned     ALU_OP_W = 3,
    parameter int unsigned     CNT_W    = 16,
    parameter logic [OP_W-1:0] HALT_OP  = OP_W'(7'h7F)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [OP_W-1:0]     ins_op,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                ir_wr,
    output logic                pc_wr,
    output logic                rg_wr,
    output logic                dataMem_wr,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                RegOut,
    output logic [1:0]          M2Reg,
    output logic                immCalc,
    output logic                busy,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired
);

    state_e          state_q;
    ctrl_word_t      cw_q;
    logic            mem_req_q;
    logic            rg_wr_q;
    logic            dm_wr_q;
    logic            busy_q;
    logic            halted_q;
    logic            illegal_q;
    logic [CNT_W-1:0] retired_q;

    ctrl_word_t      dec_cw;
    logic            dec_legal;
    logic            dec_halt;
    logic            dec_nop;

    cu_decode #(
        .OP_W    (OP_W),
        .HALT_OP (HALT_OP)
    ) u_decode (
        .op_i    (ins_op),
        .cw_o    (dec_cw),
        .legal_o (dec_legal),
        .halt_o  (dec_halt),
        .nop_o   (dec_nop)
    );

    // Sequencer: state, captured control word and all registered outputs.
    // cw_q is zero everywhere except EXEC..WB, so entering FETCH always clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cw_q      <= '0;
            mem_req_q <= 1'b0;
            rg_wr_q   <= 1'b0;
            dm_wr_q   <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            rg_wr_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_q   <= S_FETCH;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        halted_q  <= 1'b0;
                        illegal_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        state_q   <= S_DECODE;
                        mem_req_q <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (dec_halt) begin
                        state_q  <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else if (!dec_legal || dec_nop) begin
                        // Undefined opcodes behave as NOP but are not counted.
                        if (!dec_legal) begin
                            illegal_q <= 1'b1;
                        end else begin
                            retired_q <= retired_q + CNT_W'(1);
                        end
                        state_q   <= S_FETCH;
                        mem_req_q <= 1'b1;
                        cw_q      <= '0;
                    end else begin
                        state_q <= S_EXEC;
                        cw_q    <= dec_cw;
                    end
                end
                S_EXEC: begin
                    if (cw_uses_mem(cw_q)) begin
                        state_q   <= S_MEM;
                        mem_req_q <= 1'b1;
                        dm_wr_q   <= cw_q.dataMem_wr;
                    end else begin
                        state_q <= S_WB;
                        rg_wr_q <= cw_q.rg_wr;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        dm_wr_q   <= 1'b0;
                        if (cw_q.dataMem_wr) begin
                            retired_q <= retired_q + CNT_W'(1);
                            state_q   <= S_FETCH;
                            mem_req_q <= 1'b1;
                            cw_q      <= '0;
                        end else begin
                            state_q <= S_WB;
                            rg_wr_q <= cw_q.rg_wr;
                        end
                    end
                end
                S_WB: begin
                    retired_q <= retired_q + CNT_W'(1);
                    state_q   <= S_FETCH;
                    mem_req_q <= 1'b1;
                    cw_q      <= '0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    cw_q      <= '0;
                    mem_req_q <= 1'b0;
                    dm_wr_q   <= 1'b0;
                    busy_q    <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    // IR load and PC increment happen in the fetch ack cycle itself.
    assign ir_wr      = (state_q == S_FETCH) && mem_ack;
    assign pc_wr      = (state_q == S_FETCH) && mem_ack;
    assign mem_req    = mem_req_q;
    assign rg_wr      = rg_wr_q;
    assign dataMem_wr = dm_wr_q;
    assign alu_op     = ALU_OP_W'(cw_q.alu_op);

    // Select fields are shown straight from the decoder during DECODE so they
    // are valid from DECODE onward; afterwards the captured word holds them.
    assign RegOut  = (state_q == S_DECODE) ? dec_cw.RegOut  : cw_q.RegOut;
    assign M2Reg   = (state_q == S_DECODE) ? dec_cw.M2Reg   : cw_q.M2Reg;
    assign immCalc = (state_q == S_DECODE) ? dec_cw.immCalc : cw_q.immCalc;

    assign busy    = busy_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench for multicycle_cu: programs are issued with randomized
// memory latencies, expected per-instruction behaviour is queued at issue
// time and a monitor compares each instruction when it completes.
module tb_multicycle_cu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] ins_op = '0;
    logic       mem_ack = 1'b0;
    logic       mem_req, ir_wr, pc_wr, rg_wr, dataMem_wr;
    logic [2:0] alu_op;
    logic       RegOut, immCalc, busy, halted, illegal;
    logic [1:0] M2Reg;
    logic [15:0] retired;

    // Small-counter instance for the wrap test.
    logic       start2 = 1'b0;
    logic       mem_req2, ir_wr2, pc_wr2, rg_wr2, dataMem_wr2;
    logic [2:0] alu_op2;
    logic       RegOut2, immCalc2, busy2, halted2, illegal2;
    logic [1:0] M2Reg2;
    logic [1:0] retired2;

    multicycle_cu dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ins_op(ins_op), .mem_ack(mem_ack),
        .mem_req(mem_req), .ir_wr(ir_wr), .pc_wr(pc_wr), .rg_wr(rg_wr),
        .dataMem_wr(dataMem_wr), .alu_op(alu_op), .RegOut(RegOut), .M2Reg(M2Reg),
        .immCalc(immCalc), .busy(busy), .halted(halted), .illegal(illegal),
        .retired(retired)
    );

    multicycle_cu #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .ins_op(7'd0), .mem_ack(1'b1),
        .mem_req(mem_req2), .ir_wr(ir_wr2), .pc_wr(pc_wr2), .rg_wr(rg_wr2),
        .dataMem_wr(dataMem_wr2), .alu_op(alu_op2), .RegOut(RegOut2), .M2Reg(M2Reg2),
        .immCalc(immCalc2), .busy(busy2), .halted(halted2), .illegal(illegal2),
        .retired(retired2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [6:0] op;
        int         cycles;
        int         rg;
        int         dm;
        logic       regout;
        logic [1:0] m2r;
        logic       imm;
        logic       ill;
        int         ret;
        logic       halt;
    } exp_t;

    exp_t sb[$];
    int   m_ret = 0;
    bit   m_ill = 0;

    // What an instruction should do, from the ISA description:
    // cycles from its IR load to the next IR load (or to HALT).
    function automatic exp_t model_step(input logic [6:0] op, input int md, input int fd_next);
        exp_t e;
        int   base;
        e.op = op; e.rg = 0; e.dm = 0; e.regout = 0; e.m2r = 2'b00; e.imm = 0;
        e.halt = 0;
        base = 2;
        case (op)
            7'd0: m_ret = (m_ret + 1) % 65536;
            7'd1: begin base = 4; e.rg = 1; m_ret = (m_ret + 1) % 65536; end
            7'd2: begin base = 4 + md; e.dm = md + 1; e.m2r = 2'b10; m_ret = (m_ret + 1) % 65536; end
            7'd3: begin base = 4; e.rg = 1; e.regout = 1; m_ret = (m_ret + 1) % 65536; end
            7'd4: begin base = 4; e.rg = 1; e.regout = 1; e.imm = 1; m_ret = (m_ret + 1) % 65536; end
            7'd5: begin base = 5 + md; e.rg = 1; e.regout = 1; e.m2r = 2'b01; m_ret = (m_ret + 1) % 65536; end
            7'h7F: e.halt = 1;
            default: m_ill = 1;
        endcase
        e.cycles = e.halt ? base : base + fd_next;
        e.ill = m_ill;
        e.ret = m_ret;
        return e;
    endfunction

    // ---------------- monitor ----------------
    bit         inflight = 0;
    bit         prev_halted = 0;
    int         cyc, o_rg, o_dm, o_dm_noreq;
    logic       o_regout, o_imm;
    logic [1:0] o_m2r;

    task automatic evaluate();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("cycles op=%0h", e.op), cyc, e.cycles);
        chk($sformatf("rg_wr_pulses op=%0h", e.op), o_rg, e.rg);
        chk($sformatf("dm_wr_cycles op=%0h", e.op), o_dm, e.dm);
        chk($sformatf("dm_wr_without_req op=%0h", e.op), o_dm_noreq, 0);
        chk($sformatf("RegOut op=%0h", e.op), o_regout, e.regout);
        chk($sformatf("M2Reg op=%0h", e.op), o_m2r, e.m2r);
        chk($sformatf("immCalc op=%0h", e.op), o_imm, e.imm);
        chk($sformatf("illegal op=%0h", e.op), illegal, e.ill);
        chk($sformatf("retired op=%0h", e.op), retired, e.ret);
        chk($sformatf("halted op=%0h", e.op), halted, e.halt);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            inflight = 0;
            prev_halted = 0;
        end else begin
            if (inflight && (ir_wr || (halted && !prev_halted))) begin
                evaluate();
                inflight = 0;
            end
            if (ir_wr) begin
                chk("pc_wr_with_ir_wr", pc_wr, 1);
                inflight = 1; cyc = 1; o_rg = 0; o_dm = 0; o_dm_noreq = 0;
                o_regout = 0; o_m2r = 2'b00; o_imm = 0;
            end else if (inflight) begin
                cyc++;
            end
            if (inflight && rg_wr) begin
                o_rg++;
                o_regout = RegOut; o_m2r = M2Reg; o_imm = immCalc;
                chk("alu_op_in_wb", alu_op, 0);
            end
            if (inflight && dataMem_wr) begin
                o_dm++;
                o_m2r = M2Reg;
                if (!mem_req) o_dm_noreq++;
            end
            prev_halted = halted;
        end
    end

    // ---------------- stimulus ----------------
    logic [6:0] prog_op[$];
    int         prog_fd[$];
    int         prog_md[$];

    // Entered and left just after a rising edge. Serves one memory request
    // after d wait cycles; for fetches the opcode appears with the ack.
    task automatic do_access(input int d, input bit is_fetch, input logic [6:0] op);
        int g = 0;
        while (!mem_req && g < 200) begin
            @(posedge clk); #1; g++;
        end
        if (!mem_req) begin
            chk("mem_req_timeout", 0, 1);
            return;
        end
        repeat (d) begin
            @(posedge clk); #1;
        end
        mem_ack = 1'b1;
        if (is_fetch) ins_op = op;
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    task automatic run_prog();
        int n = prog_op.size();
        int g = 0;
        m_ill = 0;
        for (int i = 0; i < n; i++)
            sb.push_back(model_step(prog_op[i], prog_md[i], (i + 1 < n) ? prog_fd[i + 1] : 0));
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_clears_illegal", illegal, 0);
        chk("start_not_halted", halted, 0);
        for (int i = 0; i < n; i++) begin
            do_access(prog_fd[i], 1'b1, prog_op[i]);
            if (prog_op[i] == 7'd2 || prog_op[i] == 7'd5)
                do_access(prog_md[i], 1'b0, 7'd0);
        end
        while (!halted && g < 50) begin
            @(posedge clk); #1; g++;
        end
        chk("halt_reached", halted, 1);
        chk("halt_not_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        sb.delete();
        prog_op.delete(); prog_fd.delete(); prog_md.delete();
        @(posedge clk); #1;
    endtask

    task automatic add_ins(input logic [6:0] op, input int fd, input int md);
        prog_op.push_back(op); prog_fd.push_back(fd); prog_md.push_back(md);
    endtask

    initial begin
        int         seen;
        int         g;
        logic [1:0] last2;
        int         r;
        logic [6:0] op;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {mem_req, ir_wr, pc_wr, rg_wr, dataMem_wr, alu_op, RegOut, M2Reg, immCalc,
             busy, halted, illegal}, 0);
        chk("reset_retired", retired, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-bit counter wraps after 3 through 5 NOP retirements.
        start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        seen = 0; g = 0; last2 = retired2;
        while (seen < 5 && g < 60) begin
            @(negedge clk); g++;
            if (retired2 != last2) begin
                seen++;
                chk($sformatf("cnt2_wrap_%0d", seen), retired2, seen % 4);
                last2 = retired2;
            end
        end
        chk("cnt2_five_retires", seen, 5);
        @(posedge clk); #1;

        // ADDI with zero-wait memory.
        add_ins(7'd4, 0, 0);
        add_ins(7'h7F, 0, 0);
        run_prog();

        // LD with 3-cycle data wait, ST, illegal, NOP, then HALT.
        add_ins(7'd5, 0, 3);
        add_ins(7'd2, 1, 2);
        add_ins(7'h10, 0, 0);
        add_ins(7'd0, 2, 0);
        add_ins(7'd3, 0, 0);
        add_ins(7'd1, 0, 0);
        add_ins(7'h7F, 1, 0);
        run_prog();

        // mem_ack while halted must not restart sequencing.
        mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_ack = 1'b0;
        chk("ack_in_halt_ignored", {halted, busy, mem_req}, 3'b100);

        // Random programs.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 12; i++) begin
                r = $urandom_range(0, 9);
                if (r <= 5) op = 7'(r);
                else if (r == 6) op = 7'($urandom_range(6, 126));
                else if (r == 7) op = 7'h10;
                else op = 7'($urandom_range(1, 5));
                add_ins(op, $urandom_range(0, 2), $urandom_range(0, 3));
            end
            add_ins(7'h7F, $urandom_range(0, 2), 0);
            run_prog();
        end

        // Asynchronous reset in the middle of an ST data phase.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        do_access(0, 1'b1, 7'd2);
        g = 0;
        while (!mem_req && g < 20) begin
            @(posedge clk); #1; g++;
        end
        chk("st_mem_dm_wr", {mem_req, dataMem_wr}, 2'b11);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_drop",
            {mem_req, rg_wr, dataMem_wr, ir_wr, pc_wr, busy, halted, illegal}, 0);
        m_ret = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {busy, halted, mem_req}, 0);
        chk("post_reset_retired", retired, 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("post_reset_fetch", {busy, mem_req}, 2'b11);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
